// File: rtl/sa_operand_skewer.sv
// Purpose: diagonally skews one operand bus word per beat into the systolic array edges and sequences one K-beat frame.
// Latency: a beat accepted at edge t appears on lane i in cycle t+1+i; done coincides with the last lane N-1 element.
// Backpressure: s_ready is high only while loading; skew registers never stall and downstream is never back-pressured.
module sa_operand_skewer #(
  parameter  int N         = 2,
  parameter  int DIN_WIDTH = 8,
  parameter  int K_MAX     = 16,
  localparam int BUS_WIDTH = 2*DIN_WIDTH*N,
  localparam int KW        = $clog2(K_MAX+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [BUS_WIDTH-1:0]   s_data,
  output logic [N*DIN_WIDTH-1:0] a_out,
  output logic [N*DIN_WIDTH-1:0] b_out,
  output logic [N-1:0]           a_vld,
  output logic [N-1:0]           b_vld,
  output logic                   clear_acc,
  output logic                   busy,
  output logic                   done
);

  localparam int FW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          beat_cnt;
  logic [FW-1:0]          fl_cnt;
  logic [KW-1:0]          k_clamp;
  logic                   hs;
  logic                   last_beat;
  logic                   flush_end;
  logic                   frame_go;
  logic                   zero_go;
  logic                   clear_q;
  logic                   zero_done_q;
  logic [BUS_WIDTH-1:0]   tok_dat;

  assign s_ready   = (state_q == LOAD);
  assign hs        = s_valid && s_ready;
  assign last_beat = hs && (beat_cnt == KW'(1));
  assign flush_end = (state_q == FLUSH) && (fl_cnt == FW'(N-1));
  assign k_clamp   = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign frame_go  = (state_q == IDLE) && start && (k_len != '0);
  assign zero_go   = (state_q == IDLE) && start && (k_len == '0);

  // Stage-0 token: bubbles are zero data so lane data is 0 whenever valid is 0.
  assign tok_dat   = hs ? s_data : '0;

  assign clear_acc = clear_q;
  assign busy      = (state_q != IDLE);
  assign done      = flush_end || zero_done_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_go)  state_d = LOAD;
      LOAD:    if (last_beat) state_d = FLUSH;
      FLUSH:   if (flush_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat counter loaded with the clamped length, decremented per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        beat_cnt <= '0;
    else if (frame_go) beat_cnt <= k_clamp;
    else if (hs)       beat_cnt <= beat_cnt - KW'(1);
  end

  // Flush counter counts FLUSH cycles from 0; done fires on the N-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  fl_cnt <= '0;
    else if (state_q != FLUSH)   fl_cnt <= '0;
    else                         fl_cnt <= fl_cnt + FW'(1);
  end

  // clear_acc lands in the first LOAD cycle; zero-length frames pulse done one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_q     <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      clear_q     <= frame_go;
      zero_done_q <= zero_go;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [i:0][DIN_WIDTH-1:0] a_dly;
    logic [i:0][DIN_WIDTH-1:0] b_dly;
    logic [i:0]                v_dly;

    // Lane i delay line of i+1 registers; always advances, never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_dly <= '0;
        b_dly <= '0;
        v_dly <= '0;
      end else begin
        a_dly[0] <= tok_dat[DIN_WIDTH*i +: DIN_WIDTH];
        b_dly[0] <= tok_dat[N*DIN_WIDTH + DIN_WIDTH*i +: DIN_WIDTH];
        v_dly[0] <= hs;
        for (int s = 1; s <= i; s++) begin
          a_dly[s] <= a_dly[s-1];
          b_dly[s] <= b_dly[s-1];
          v_dly[s] <= v_dly[s-1];
        end
      end
    end

    assign a_out[DIN_WIDTH*i +: DIN_WIDTH] = a_dly[i];
    assign b_out[DIN_WIDTH*i +: DIN_WIDTH] = b_dly[i];
    assign a_vld[i]                        = v_dly[i];
    assign b_vld[i]                        = v_dly[i];
  end

endmodule

// File: tb/tb_sa_operand_skewer.sv
// Purpose: directed self-checking bench for sa_operand_skewer with N=2, DIN_WIDTH=8, K_MAX=16.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled on the falling edge.
// Backpressure: bench holds s_valid as directed and relies on s_ready to gate acceptance.
module tb_sa_operand_skewer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  k_len;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [1:0]  a_vld;
  logic [1:0]  b_vld;
  logic        clear_acc;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sa_operand_skewer #(.N(2), .DIN_WIDTH(8), .K_MAX(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .a_out     (a_out),
    .b_out     (b_out),
    .a_vld     (a_vld),
    .b_vld     (b_vld),
    .clear_acc (clear_acc),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Beat k: A row0=0x0k row1=0x1k, B col0=0x2k col1=0x3k.
  function automatic logic [31:0] mk(input int k);
    return {8'(48 + k), 8'(32 + k), 8'(16 + k), 8'(k)};
  endfunction

  // Drive one cycle of inputs, check that cycle's outputs, advance to the next cycle.
  task automatic step(input logic st, input logic [4:0] kl, input logic sv, input logic [31:0] sd,
                      input logic [15:0] ea, input logic [15:0] eb, input logic [1:0] ev,
                      input logic erdy, input logic ecl, input logic ebusy, input logic edone);
    start   = st;
    k_len   = kl;
    s_valid = sv;
    s_data  = sd;
    @(negedge clk);
    chk("a_out",     32'(a_out),     32'(ea));
    chk("b_out",     32'(b_out),     32'(eb));
    chk("a_vld",     32'(a_vld),     32'(ev));
    chk("b_vld",     32'(b_vld),     32'(ev));
    chk("s_ready",   32'(s_ready),   32'(erdy));
    chk("clear_acc", 32'(clear_acc), 32'(ecl));
    chk("busy",      32'(busy),      32'(ebusy));
    chk("done",      32'(done),      32'(edone));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_step();
    step(1'b0, 5'd0, 1'b0, 32'd0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Frame with s_valid held high. Cycle j=1 is the first LOAD cycle; beat j-1 offered in cycle j.
  // Lane0 shows beat j-2, lane1 beat j-3; done in cycle keff+2. poke re-asserts start mid-LOAD
  // and in the done cycle. abort_j asserts reset in that cycle instead of continuing.
  task automatic run_frame(input logic [4:0] kreq, input int keff, input bit poke, input int abort_j);
    logic [7:0] l0a, l1a, l0b, l1b;
    logic       v0, v1;
    logic       st;
    step(1'b1, kreq, 1'b0, 32'd0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 1; j <= keff + 2; j++) begin
      if (j == abort_j) begin
        rst_n = 1'b0;
        step(1'b0, 5'd0, 1'b1, mk(j - 1), 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_step();
        rst_n = 1'b1;
        idle_step();
        idle_step();
        return;
      end
      v0  = (j >= 2) && (j <= keff + 1);
      v1  = (j >= 3) && (j <= keff + 2);
      l0a = v0 ? 8'(j - 2)      : 8'h00;
      l1a = v1 ? 8'(16 + j - 3) : 8'h00;
      l0b = v0 ? 8'(32 + j - 2) : 8'h00;
      l1b = v1 ? 8'(48 + j - 3) : 8'h00;
      st  = poke && ((j == 2) || (j == keff + 2));
      step(st, 5'd5, 1'b1, mk(j - 1), {l1a, l0a}, {l1b, l0b}, {v1, v0},
           (j <= keff), (j == 1), 1'b1, (j == keff + 2));
    end
    idle_step();
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    k_len   = 5'd0;
    s_valid = 1'b0;
    s_data  = 32'd0;
    #1;
    // Reset state, including start requests while held in reset.
    step(1'b1, 5'd3, 1'b1, mk(0), 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_step();
    rst_n = 1'b1;
    idle_step();

    // Scenario 1: k_len=3, s_valid high (continues high into FLUSH, must not be accepted).
    step(1'b1, 5'd3, 1'b0, 32'd0,  16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, mk(0),  16'h0000, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, mk(1),  16'h0000, 16'h0020, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, mk(2),  16'h1001, 16'h3021, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, mk(3),  16'h1102, 16'h3122, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, mk(4),  16'h1200, 16'h3200, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_step();

    // Scenario 2: k_len=3, s_valid pattern 1,0,1,1.
    step(1'b1, 5'd3, 1'b0, 32'd0,  16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, mk(0),  16'h0000, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b0, mk(9),  16'h0000, 16'h0020, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, mk(1),  16'h1000, 16'h3000, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, mk(2),  16'h0001, 16'h0021, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b0, 32'd0,  16'h1102, 16'h3122, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b0, 32'd0,  16'h1200, 16'h3200, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_step();

    // Scenario 3: zero-length frame, offered data must not be accepted.
    step(1'b1, 5'd0, 1'b1, mk(5),  16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, mk(6),  16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_step();

    // Scenario 4: k_len=20 clamps to 16 beats.
    run_frame(5'd20, 16, 1'b0, 0);

    // Scenario 4b: k_len exactly K_MAX.
    run_frame(5'd16, 16, 1'b0, 0);

    // Scenario 5: stray starts mid-LOAD and in the done cycle are ignored, then a fresh frame.
    run_frame(5'd3, 3, 1'b1, 0);
    run_frame(5'd2, 2, 1'b0, 0);

    // Scenario 6: reset in the first FLUSH cycle with both lanes valid, then a normal frame.
    run_frame(5'd3, 3, 1'b0, 4);
    run_frame(5'd3, 3, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_operand_skewer.md
Name: sa_operand_skewer

Overview:
- Feeder stage directly upstream of a systolic array instance.
- Accepts one operand bus word per beat, carrying column k of A (N row elements) and row k of B (N column elements).
- Applies diagonal skew so that lane i reaches array edge i delayed i cycles relative to lane 0.
- Sequences one K-length frame per start command; pulses clear to the array before data and done when the last skewed element is presented.

Parameters:
- N, 2, array edge dimension (rows of A fed = columns of B fed).
- DIN_WIDTH, 8, operand element width in bits.
- BUS_WIDTH, 2*DIN_WIDTH*N, input bus width; derived, not overridden.
- K_MAX, 16, maximum frame length in beats.
- KW, $clog2(K_MAX+1), width of k_len; derived.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame start pulse; sampled only in IDLE.
- k_len  in  KW  beats in frame; sampled with start; values above K_MAX are clamped to K_MAX.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  BUS_WIDTH  bits [DIN_WIDTH*i +: DIN_WIDTH] = A element for row i; bits [N*DIN_WIDTH + DIN_WIDTH*j +: DIN_WIDTH] = B element for column j.
- a_out  out  N*DIN_WIDTH  skewed A row lanes, same packing as input.
- b_out  out  N*DIN_WIDTH  skewed B column lanes.
- a_vld  out  N  per-lane A valid.
- b_vld  out  N  per-lane B valid.
- clear_acc  out  1  one-cycle pulse telling the array to zero its accumulators.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.

Behaviour:
Reset:
- All outputs are 0 and all skew registers are zero/invalid.
- FSM is in IDLE.
- Reset asserted mid-frame aborts the frame; no done pulse is issued.

FSM states:
- IDLE:
  - start with k_len!=0: latch min(k_len, K_MAX) into beat counter, go to LOAD, and pulse clear_acc in the first LOAD cycle.
  - start with k_len==0: stay IDLE and pulse done in the next cycle; no clear_acc, busy stays low.
- LOAD:
  - s_ready=1.
  - Each s_valid&&s_ready handshake decrements the counter.
  - After the handshake that takes the counter to 0, go to FLUSH.
- FLUSH:
  - s_ready=0.
  - Flush counter runs N cycles starting the cycle after the last accept.
  - done pulses on the N-th FLUSH cycle; return to IDLE on the following edge.
- Other rules:
  - busy=1 in every LOAD and FLUSH cycle, including the done cycle.
  - start in LOAD or FLUSH is ignored.

Skew datapath:
- Per cycle, a stage-0 token is formed: data = s_data if handshake, else zero; valid = handshake.
- A lane i and B lane i each pass through a registered delay of i+1 cycles.
- A beat accepted at edge t therefore appears on lane i in cycle t+1+i, with a_vld[i]/b_vld[i]=1.
- Non-handshake cycles (bubbles when s_valid=0 in LOAD) propagate uniformly as zero data with valid=0, so diagonal alignment is preserved.
- The block never back-pressures the array and never stalls a skew register.
- Lane data is 0 whenever its valid is 0.
- Last accept at edge t:
  - Lane N-1 presents its last valid element in cycle t+N.
  - done coincides with that cycle.
- clear_acc precedes the first valid lane-0 element by at least 1 cycle.

Boundaries:
- N=1: single-cycle FLUSH; done coincides with the last lane-0 valid.
- k_len=K_MAX: counter must not wrap.
- s_valid held high: back-to-back beats, no bubbles.
- start in the same cycle as done: ignored, because the FSM is not yet IDLE.

Test Plan:
1. N=2, start k_len=3, s_valid held high, A col k = {row1=0x1k, row0=0x0k}, B likewise 0x2k/0x3k.
   - clear_acc pulses in the first LOAD cycle.
   - a_out lane0 shows 0x00,0x01,0x02 in cycles t1..t1+2; lane1 shows 0x10,0x11,0x12 one cycle later.
   - done pulses the same cycle as lane1 0x12; busy drops the next cycle.
2. k_len=3 with s_valid pattern 1,0,1,1.
   - Lane0 valid pattern is 1,0,1,1 with zero data in the gap.
   - Lane1 shows the identical pattern shifted by 1; done pulses 2 cycles after the final accept.
3. start with k_len=0 -> done pulses the next cycle; busy, clear_acc and all valids stay 0.
4. k_len=20 (> K_MAX=16) -> exactly 16 handshakes accepted, then s_ready=0 and done as in scenario 1 timing.
5. Second start asserted mid-LOAD and in the done cycle -> ignored; a fresh start in IDLE runs a normal frame.
6. rst_n asserted mid-FLUSH with valids in flight -> all outputs 0 immediately, no done; a subsequent frame behaves as in scenario 1.
